// File: rtl/ifetch_queue_stage.sv
// Decoupled instruction fetch: PC generator, in-order memory port and a
// depth_p-entry instruction queue; redirects flush and drop stale responses.
module ifetch_queue_stage #(
    parameter int width_p = 32,
    parameter int depth_p = 4,
    parameter logic [width_p-1:0] reset_pc_p = '0,
    parameter int pc_inc_p = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               imem_req_v_o,
    output logic [width_p-1:0] imem_req_addr_o,
    input  logic               imem_req_ready_i,
    input  logic               imem_resp_v_i,
    input  logic [width_p-1:0] imem_resp_data_i,
    input  logic               redirect_v_i,
    input  logic [width_p-1:0] redirect_pc_i,
    output logic               inst_v_o,
    output logic [width_p-1:0] inst_o,
    output logic [width_p-1:0] pc_o,
    input  logic               inst_yumi_i
);
    localparam int idx_w_lp = $clog2(depth_p);
    localparam int ptr_w_lp = idx_w_lp + 1;

    typedef logic [ptr_w_lp-1:0] ptr_t;

    localparam ptr_t depth_lp = ptr_t'(depth_p);
    localparam ptr_t one_lp = ptr_t'(1);

    logic [width_p-1:0] fetch_pc_q, fetch_pc_d;
    ptr_t alloc_q, alloc_d;
    ptr_t fill_q, fill_d;
    ptr_t read_q, read_d;
    ptr_t drop_cnt_q, drop_cnt_d;

    logic [width_p-1:0] pc_mem_q [depth_p];
    logic [width_p-1:0] data_mem_q [depth_p];

    ptr_t allocated, pending, filled, drop_sum;
    logic req_v, fire, inst_v, deq;
    logic resp_drop, resp_wr;

    assign allocated = alloc_q - read_q;
    assign pending   = alloc_q - fill_q;
    assign filled    = fill_q - read_q;

    assign req_v = ~rst_i & ~redirect_v_i & (allocated < depth_lp)
                 & (drop_cnt_q == '0);
    assign fire  = req_v & imem_req_ready_i;

    assign inst_v = (filled != '0) & ~redirect_v_i;
    assign deq    = inst_v & inst_yumi_i;

    assign resp_drop = imem_resp_v_i & (drop_cnt_q != '0);
    assign resp_wr   = imem_resp_v_i & (drop_cnt_q == '0)
                     & (pending != '0) & ~redirect_v_i;

    // Everything still owed by memory becomes garbage on a redirect.
    assign drop_sum = drop_cnt_q + pending;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        read_d     = read_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_v_i) begin
            fetch_pc_d = redirect_pc_i;
            alloc_d    = read_q;
            fill_d     = read_q;
            drop_cnt_d = drop_sum;
            if (imem_resp_v_i && drop_sum != '0) begin
                drop_cnt_d = drop_sum - one_lp;
            end
        end else begin
            if (fire) begin
                fetch_pc_d = fetch_pc_q + width_p'(pc_inc_p);
                alloc_d    = alloc_q + one_lp;
            end
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - one_lp;
            end
            if (resp_wr) begin
                fill_d = fill_q + one_lp;
            end
            if (deq) begin
                read_d = read_q + one_lp;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q <= reset_pc_p;
            alloc_q    <= '0;
            fill_q     <= '0;
            read_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            read_q     <= read_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire) begin
            pc_mem_q[alloc_q[idx_w_lp-1:0]] <= fetch_pc_q;
        end
        if (resp_wr) begin
            data_mem_q[fill_q[idx_w_lp-1:0]] <= imem_resp_data_i;
        end
    end

    // A response with nothing outstanding and nothing to drop is illegal.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(imem_resp_v_i && drop_cnt_q == '0 && pending == '0));
        end
    end

    assign imem_req_v_o    = req_v;
    assign imem_req_addr_o = fetch_pc_q;
    assign inst_v_o        = inst_v;
    assign inst_o          = data_mem_q[read_q[idx_w_lp-1:0]];
    assign pc_o            = pc_mem_q[read_q[idx_w_lp-1:0]];

endmodule
